// File: rtl/life_engine_if.sv
// Control and observation bundle for life_engine. Signal suffixes are taken from
// the engine's point of view: the engine uses the slave modport.
interface life_engine_if #(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned COLS   = 16,
  parameter int unsigned GEN_W  = 16,
  parameter int unsigned RATE_W = 26
);
  localparam int unsigned RW = $clog2(ROWS);

  logic                  step_i;
  logic                  run_i;
  logic [RATE_W-1:0]     rate_i;
  logic                  clear_i;
  logic                  load_i;
  logic [RW-1:0]         load_row_i;
  logic [COLS-1:0]       load_data_i;
  logic [ROWS*COLS-1:0]  board_o;
  logic [GEN_W-1:0]      generation_cnt_o;
  logic                  busy_o;
  logic                  gen_done_o;
  logic                  stable_o;

  modport master (
    output step_i, run_i, rate_i, clear_i, load_i, load_row_i, load_data_i,
    input  board_o, generation_cnt_o, busy_o, gen_done_o, stable_o
  );

  modport slave (
    input  step_i, run_i, rate_i, clear_i, load_i, load_row_i, load_data_i,
    output board_o, generation_cnt_o, busy_o, gen_done_o, stable_o
  );
endinterface

// File: rtl/life_engine.sv
// Game of Life generation engine: one row per cycle into a shadow board, then an
// atomic commit, with single-step, timed free-run, row load, clear and still-life flag.
module life_engine #(
  parameter int unsigned ROWS           = 16,
  parameter int unsigned COLS           = 16,
  parameter int unsigned GEN_W          = 16,
  parameter bit          WRAP           = 1'b1,
  parameter int unsigned RATE_W         = 26,
  parameter bit          HALT_ON_STABLE = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  life_engine_if.slave bus_io
);
  localparam int unsigned RW = $clog2(ROWS);

  typedef enum logic [1:0] {StIdle, StCompute, StCommit} state_e;

  state_e              state_q, state_d;
  logic [COLS-1:0]     board_q [ROWS];
  logic [COLS-1:0]     board_d [ROWS];
  logic [COLS-1:0]     shadow_q [ROWS];
  logic [COLS-1:0]     shadow_d [ROWS];
  logic [GEN_W-1:0]    cnt_q, cnt_d;
  logic [RATE_W-1:0]   tick_q, tick_d;
  logic [RW-1:0]       row_q, row_d;
  logic                stable_q, stable_d;
  logic                done_q, done_d;

  logic [ROWS*COLS-1:0] board_flat, shadow_flat;
  logic                 run_trig;
  logic                 row_ok;

  logic [RW-1:0]   row_up, row_dn;
  logic [COLS-1:0] up_r, mid_r, dn_r;
  logic [COLS+1:0] up_e, mid_e, dn_e;
  logic [3:0]      nbr;
  logic [COLS-1:0] next_row;

  for (genvar g = 0; g < ROWS; g++) begin : g_flat
    assign board_flat[g*COLS +: COLS]  = board_q[g];
    assign shadow_flat[g*COLS +: COLS] = shadow_q[g];
  end

  // Indices past ROWS-1 only exist when ROWS is not a power of two.
  if (ROWS == (1 << RW)) begin : g_row_pow2
    assign row_ok = 1'b1;
  end else begin : g_row_chk
    assign row_ok = (32'(bus_io.load_row_i) < ROWS);
  end

  // Neighbourhood of the row being computed, always read from the committed board.
  always_comb begin
    row_up = (row_q == '0) ? RW'(ROWS - 1) : row_q - 1'b1;
    row_dn = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    up_r   = board_q[row_up];
    mid_r  = board_q[row_q];
    dn_r   = board_q[row_dn];
    if (!WRAP && row_q == '0) begin
      up_r = '0;
    end
    if (!WRAP && row_q == RW'(ROWS - 1)) begin
      dn_r = '0;
    end
    // Extended rows: bit 0 is the left neighbour of column 0, bit COLS+1 the right of COLS-1.
    up_e  = WRAP ? {up_r[0], up_r, up_r[COLS-1]}    : {1'b0, up_r, 1'b0};
    mid_e = WRAP ? {mid_r[0], mid_r, mid_r[COLS-1]} : {1'b0, mid_r, 1'b0};
    dn_e  = WRAP ? {dn_r[0], dn_r, dn_r[COLS-1]}    : {1'b0, dn_r, 1'b0};
    nbr      = '0;
    next_row = '0;
    for (int c = 0; c < COLS; c++) begin
      nbr = 4'(up_e[c]) + 4'(up_e[c+1]) + 4'(up_e[c+2]) +
            4'(mid_e[c]) + 4'(mid_e[c+2]) +
            4'(dn_e[c]) + 4'(dn_e[c+1]) + 4'(dn_e[c+2]);
      next_row[c] = (nbr == 4'd3) || ((nbr == 4'd2) && mid_r[c]);
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    tick_d   = '0;
    row_d    = row_q;
    stable_d = stable_q;
    done_d   = 1'b0;
    run_trig = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.run_i) begin
          if (tick_q >= bus_io.rate_i) begin
            run_trig = !(HALT_ON_STABLE && stable_q);
            // Saturate so a masked or pre-empted trigger fires as soon as allowed.
            tick_d   = tick_q;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        if (bus_io.load_i) begin
          if (row_ok) begin
            board_d[bus_io.load_row_i] = bus_io.load_data_i;
          end
          stable_d = 1'b0;
        end else if (bus_io.step_i || run_trig) begin
          state_d = StCompute;
          row_d   = '0;
          tick_d  = '0;
        end
      end
      StCompute: begin
        shadow_d[row_q] = next_row;
        if (row_q == RW'(ROWS - 1)) begin
          state_d = StCommit;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      StCommit: begin
        board_d  = shadow_q;
        stable_d = (shadow_flat == board_flat);
        cnt_d    = cnt_q + 1'b1;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear wins in every state; mid-generation it also discards the shadow.
    if (bus_io.clear_i) begin
      state_d  = StIdle;
      row_d    = '0;
      tick_d   = '0;
      cnt_d    = '0;
      stable_d = 1'b0;
      done_d   = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        board_d[r]  = '0;
        shadow_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      tick_q   <= '0;
      row_q    <= '0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        board_q[r]  <= '0;
        shadow_q[r] <= '0;
      end
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      row_q    <= row_d;
      stable_q <= stable_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.board_o          = board_flat;
  assign bus_io.generation_cnt_o = cnt_q;
  assign bus_io.busy_o           = (state_q != StIdle);
  assign bus_io.gen_done_o       = done_q;
  assign bus_io.stable_o         = stable_q;

  a_board_frozen_in_compute: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StCompute && !bus_io.clear_i) |=> (board_flat == $past(board_flat)));

  a_done_only_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> (state_q == StIdle));

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: a toroidal 16-bit-counter instance and a dead-edge 4-bit-counter
// instance, checked against a software Life model through a scoreboard queue.
module tb_life_engine;
  typedef struct {
    string        name;
    int           dut;
    logic [255:0] init;
    int           steps;
    logic [255:0] exp_board;
    logic         exp_stable;
  } vec_t;

  typedef struct {
    logic [255:0] board;
    logic [15:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step = 1'b0, run = 1'b0, clear = 1'b0, load = 1'b0;
  logic [25:0] rate = '0;
  logic [3:0]  lrow = '0;
  logic [15:0] ldata = '0;
  int sel = 0;

  logic [255:0] board;
  logic [15:0]  cnt;
  logic         busy, done, stable;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done = 0;
  int mcnt = 0;
  logic [255:0] mb = '0;
  exp_t sbq [$];
  vec_t vt [6];
  logic [255:0] blk_h, blk_v, block, glider, glider_sh, corner_blk;
  int t1, t2;

  life_engine_if #(.ROWS(16), .COLS(16), .GEN_W(16), .RATE_W(26)) ifa ();
  life_engine_if #(.ROWS(16), .COLS(16), .GEN_W(4), .RATE_W(26)) ifb ();

  life_engine #(.ROWS(16), .COLS(16), .GEN_W(16), .WRAP(1'b1), .RATE_W(26),
                .HALT_ON_STABLE(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus_io(ifa));
  life_engine #(.ROWS(16), .COLS(16), .GEN_W(4), .WRAP(1'b0), .RATE_W(26),
                .HALT_ON_STABLE(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus_io(ifb));

  assign ifa.step_i      = step & (sel == 0);
  assign ifa.run_i       = run & (sel == 0);
  assign ifa.clear_i     = clear & (sel == 0);
  assign ifa.load_i      = load & (sel == 0);
  assign ifa.rate_i      = rate;
  assign ifa.load_row_i  = lrow;
  assign ifa.load_data_i = ldata;
  assign ifb.step_i      = step & (sel == 1);
  assign ifb.run_i       = run & (sel == 1);
  assign ifb.clear_i     = clear & (sel == 1);
  assign ifb.load_i      = load & (sel == 1);
  assign ifb.rate_i      = rate;
  assign ifb.load_row_i  = lrow;
  assign ifb.load_data_i = ldata;

  always_comb begin
    if (sel == 0) begin
      board  = ifa.board_o;
      cnt    = ifa.generation_cnt_o;
      busy   = ifa.busy_o;
      done   = ifa.gen_done_o;
      stable = ifa.stable_o;
    end else begin
      board  = ifb.board_o;
      cnt    = {12'h000, ifb.generation_cnt_o};
      busy   = ifb.busy_o;
      done   = ifb.gen_done_o;
      stable = ifb.stable_o;
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] put(input logic [255:0] b, input int r, input int c);
    b[8'(r*16 + c)] = 1'b1;
    return b;
  endfunction

  function automatic logic [255:0] life_next(input logic [255:0] b, input bit wrap);
    logic [255:0] nb;
    int n, rr, cc;
    nb = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 16) % 16;
              cc = (cc + 16) % 16;
            end else if (rr < 0 || rr > 15 || cc < 0 || cc > 15) begin
              continue;
            end
            n += int'(b[8'(rr*16 + cc)]);
          end
        end
        nb[8'(r*16 + c)] = (n == 3) || (n == 2 && b[8'(r*16 + c)]);
      end
    end
    return nb;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic predict();
    exp_t e;
    mb = life_next(mb, (sel == 0));
    mcnt = (mcnt + 1) % ((sel == 0) ? 65536 : 16);
    e.board = mb;
    e.cnt = 16'(mcnt);
    sbq.push_back(e);
  endtask

  task automatic do_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
    predict();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    mb = '0;
    mcnt = 0;
    sbq.delete();
  endtask

  task automatic load_board(input logic [255:0] b);
    for (int r = 0; r < 16; r++) begin
      load = 1'b1;
      lrow = 4'(r);
      ldata = b[8'(r*16) +: 16];
      cycle();
    end
    load = 1'b0;
    mb = b;
  endtask

  task automatic wait_done(input int budget);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL gen_done_timeout: got no pulse want pulse within %0d cycles", budget);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_gen_done: got pulse want none");
    end else begin
      last_done = cyc;
      e = sbq.pop_front();
      chk("sb_board", board, e.board);
      chk("sb_cnt", cnt, e.cnt);
    end
  endtask

  task automatic quiet(input int n, input string name);
    int k;
    k = 0;
    repeat (n) begin
      cycle();
      if (done) k++;
    end
    chk(name, k, 0);
  endtask

  initial begin
    blk_h      = put(put(put('0, 5, 4), 5, 5), 5, 6);
    blk_v      = put(put(put('0, 4, 5), 5, 5), 6, 5);
    block      = put(put(put(put('0, 7, 7), 7, 8), 8, 7), 8, 8);
    glider     = put(put(put(put(put('0, 13, 14), 14, 15), 15, 13), 15, 14), 15, 15);
    glider_sh  = put(put(put(put(put('0, 14, 15), 15, 0), 0, 14), 0, 15), 0, 0);
    corner_blk = put(put(put(put('0, 14, 14), 14, 15), 15, 14), 15, 15);

    vt[0] = '{"blinker1", 0, blk_h, 1, blk_v, 1'b0};
    vt[1] = '{"blinker2", 0, blk_h, 2, blk_h, 1'b0};
    vt[2] = '{"block", 0, block, 1, block, 1'b1};
    vt[3] = '{"glider_wrap", 0, glider, 4, glider_sh, 1'b0};
    vt[4] = '{"glider_dead", 1, glider, 4, corner_blk, 1'b1};
    vt[5] = '{"empty", 0, '0, 1, '0, 1'b1};

    // Reset state of both instances
    repeat (3) cycle();
    sel = 0;
    chk("rst_a_board", board, '0);
    chk("rst_a_cnt", cnt, 0);
    chk("rst_a_busy", busy, 0);
    chk("rst_a_done", done, 0);
    chk("rst_a_stable", stable, 0);
    sel = 1;
    #1;
    chk("rst_b_board", board, '0);
    chk("rst_b_cnt", cnt, 0);
    sel = 0;
    rst_n = 1'b1;
    cycle();

    // Blinker latency: trigger sampled on edge 1, board changes on edge 18
    do_clear();
    load_board(blk_h);
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("lat_busy_start", busy, 1);
    for (int i = 2; i <= 18; i++) begin
      cycle();
      if (i == 17) begin
        chk("lat_board_frozen", board, blk_h);
        chk("lat_busy17", busy, 1);
        chk("lat_done17", done, 0);
      end
    end
    chk("lat_board18", board, blk_v);
    chk("lat_cnt18", cnt, 1);
    chk("lat_done18", done, 1);
    chk("lat_busy18", busy, 0);
    cycle();
    chk("lat_done_pulse", done, 0);

    foreach (vt[i]) begin
      sel = vt[i].dut;
      cycle();
      do_clear();
      load_board(vt[i].init);
      for (int s = 0; s < vt[i].steps; s++) begin
        do_step();
        wait_done(40);
      end
      chk({vt[i].name, "_board"}, board, vt[i].exp_board);
      chk({vt[i].name, "_stable"}, stable, vt[i].exp_stable);
    end

    // Free-run periods
    sel = 0;
    cycle();
    do_clear();
    load_board(blk_h);
    rate = 26'd5;
    run = 1'b1;
    predict();
    wait_done(60);
    t1 = last_done;
    predict();
    wait_done(60);
    t2 = last_done;
    run = 1'b0;
    chk("run_rate5_period", t2 - t1, 23);
    quiet(40, "run_off_quiet");

    do_clear();
    load_board(blk_h);
    rate = '0;
    run = 1'b1;
    predict();
    wait_done(60);
    t1 = last_done;
    predict();
    wait_done(60);
    t2 = last_done;
    run = 1'b0;
    chk("run_rate0_period", t2 - t1, 18);
    quiet(30, "run0_off_quiet");

    // Still life halts free-run
    do_clear();
    load_board(block);
    rate = '0;
    run = 1'b1;
    predict();
    wait_done(60);
    chk("halt_stable", stable, 1);
    quiet(100, "halt_no_done");
    chk("halt_cnt", cnt, 1);
    run = 1'b0;

    // Clear aborts a generation at row 7
    do_clear();
    load_board(blk_h);
    do_step();
    wait_done(40);
    step = 1'b1;
    cycle();
    step = 1'b0;
    repeat (7) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    mb = '0;
    mcnt = 0;
    chk("abort_busy", busy, 0);
    chk("abort_board", board, '0);
    chk("abort_cnt", cnt, 0);
    quiet(30, "abort_no_done");

    // Load while busy is dropped
    load_board(blk_h);
    do_step();
    cycle();
    load = 1'b1;
    lrow = 4'd0;
    ldata = 16'hFFFF;
    cycle();
    load = 1'b0;
    wait_done(40);

    // Step and clear together: clear wins
    step = 1'b1;
    clear = 1'b1;
    cycle();
    step = 1'b0;
    clear = 1'b0;
    mb = '0;
    mcnt = 0;
    chk("stepclr_busy", busy, 0);
    chk("stepclr_cnt", cnt, 0);
    chk("stepclr_board", board, '0);
    quiet(25, "stepclr_no_done");

    // Reset mid-compute
    load_board(blk_h);
    step = 1'b1;
    cycle();
    step = 1'b0;
    repeat (5) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    mb = '0;
    mcnt = 0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_board", board, '0);
    quiet(25, "rstmid_no_done");

    // 4-bit counter wraps 15 -> 0
    sel = 1;
    cycle();
    do_clear();
    load_board(blk_h);
    for (int k = 0; k < 16; k++) begin
      do_step();
      wait_done(40);
    end
    chk("gen4_wrap_cnt", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
